// File: rtl/drive_indicator.sv
// Turn-signal blinker and BCD mileage counter driven by the manual driving controller.
// Latency: inputs registered once; LEDs/moving follow one cycle later, mileage steps on the prescaler wrap.
// Backpressure: none; free-running indicator logic that accepts a new command every cycle.
module drive_indicator #(
  parameter int BLINK_HALF  = 50_000_000,
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power_on,
  input  logic [3:0]  move_cmd,
  output logic        left_led,
  output logic        right_led,
  output logic        moving,
  output logic [15:0] mileage_bcd
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);

  // move_cmd bit positions
  localparam int CMD_FWD   = 0;
  localparam int CMD_BACK  = 1;
  localparam int CMD_RIGHT = 2;
  localparam int CMD_LEFT  = 3;

  logic          pwr_q;
  logic [3:0]    cmd_q;
  logic          turn_act;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [TW-1:0] tick_cnt;

  // Increment a four-digit BCD value; 9999 rolls over to 0000 silently.
  // Any digit >= 9 is treated as 9 so an out-of-range digit can never persist.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Capture the controller inputs once; everything downstream uses these copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_q <= 1'b0;
      cmd_q <= 4'd0;
    end else begin
      pwr_q <= power_on;
      cmd_q <= move_cmd;
    end
  end

  assign turn_act = pwr_q & (cmd_q[CMD_LEFT] | cmd_q[CMD_RIGHT]);

  // Blink prescaler: runs only while a turn is requested; idles with the phase ON
  // so a fresh request lights immediately, and keeps phase across left<->right swaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!pwr_q) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (turn_act) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end
  end

  // Mileage prescaler and BCD counter: the prescaler pauses (keeping the partial
  // unit) while stopped; power-off wipes both and wins over a coincident wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      mileage_bcd <= 16'h0000;
    end else if (!pwr_q) begin
      tick_cnt    <= '0;
      mileage_bcd <= 16'h0000;
    end else if (moving) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt    <= '0;
        mileage_bcd <= bcd_inc(mileage_bcd);
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Outputs are pure functions of the registered inputs and blink phase.
  always_comb begin
    moving    = pwr_q & (cmd_q[CMD_FWD] | cmd_q[CMD_BACK]);
    left_led  = pwr_q & cmd_q[CMD_LEFT]  & blink_phase;
    right_led = pwr_q & cmd_q[CMD_RIGHT] & blink_phase;
  end

endmodule

// File: tb/tb_drive_indicator.sv
// Bench for drive_indicator: directed scenarios plus random command runs against a reference model.
// Latency: compares one cycle after each rising edge's input registration.
// Backpressure: not applicable.
module tb_drive_indicator;

  localparam int BH = 4;
  localparam int TC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        power_on = 1'b0;
  logic [3:0]  move_cmd = 4'd0;
  logic        left_led, right_led, moving;
  logic [15:0] mileage_bcd;

  logic        f_power = 1'b0;
  logic [3:0]  f_cmd = 4'd0;
  logic        f_left, f_right, f_moving;
  logic [15:0] f_mileage;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic        m_pwr;
  logic [3:0]  m_cmd;
  int          blink_el;
  int          tick_total;

  always #5 clk = ~clk;

  drive_indicator #(.BLINK_HALF(BH), .TICK_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .power_on(power_on), .move_cmd(move_cmd),
    .left_led(left_led), .right_led(right_led), .moving(moving), .mileage_bcd(mileage_bcd)
  );

  drive_indicator #(.BLINK_HALF(2), .TICK_CYCLES(1)) fast (
    .clk(clk), .rst_n(rst_n), .power_on(f_power), .move_cmd(f_cmd),
    .left_led(f_left), .right_led(f_right), .moving(f_moving), .mileage_bcd(f_mileage)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int u);
    return {4'(u / 1000 % 10), 4'(u / 100 % 10), 4'(u / 10 % 10), 4'(u % 10)};
  endfunction

  function automatic int units();
    return (tick_total / TC) % 10000;
  endfunction

  task automatic model_reset();
    m_pwr = 1'b0; m_cmd = 4'd0; blink_el = 0; tick_total = 0;
  endtask

  task automatic check_model();
    logic phase;
    phase = ((blink_el / BH) % 2) == 0;
    chk("left_led",  16'(left_led),  16'(m_pwr & m_cmd[3] & phase));
    chk("right_led", 16'(right_led), 16'(m_pwr & m_cmd[2] & phase));
    chk("moving",    16'(moving),    16'(m_pwr & (m_cmd[1] | m_cmd[0])));
    chk("mileage",   mileage_bcd,    to_bcd(units()));
  endtask

  // Apply inputs, clock once, advance the model with the previously registered values.
  task automatic cyc(input logic p, input logic [3:0] c);
    power_on = p;
    move_cmd = c;
    @(posedge clk);
    if (!m_pwr) begin
      blink_el   = 0;
      tick_total = 0;
    end else begin
      if (m_cmd[3] | m_cmd[2]) blink_el++;
      else blink_el = 0;
      if (m_cmd[1] | m_cmd[0]) tick_total++;
    end
    m_pwr = p;
    m_cmd = c;
    #1;
    check_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic p;
    logic [3:0] c;
    model_reset();

    // reset state
    #12;
    chk("rst_left", 16'(left_led), 16'd0);
    chk("rst_right", 16'(right_led), 16'd0);
    chk("rst_moving", 16'(moving), 16'd0);
    chk("rst_mileage", mileage_bcd, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // left blink: on 4, off 4, first lit one cycle after change
    cyc(1'b1, 4'b1000);
    chk("blink_first_on", 16'(left_led), 16'd1);
    for (int k = 1; k < 16; k++) begin
      cyc(1'b1, 4'b1000);
      chk("blink_pattern", 16'(left_led), 16'(((k / 4) % 2) == 0));
      chk("blink_right_off", 16'(right_led), 16'd0);
    end

    // both turns blink in phase, period 8
    cyc(1'b1, 4'b0000);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 4'b1100);
      chk("both_equal", 16'(left_led), 16'(right_led));
      chk("both_pattern", 16'(left_led), 16'(((k / 4) % 2) == 0));
    end

    // left -> right swap keeps phase (model tracks continuity)
    repeat (6) cyc(1'b1, 4'b1000);
    repeat (6) cyc(1'b1, 4'b0100);

    // mileage accumulation with held partial unit
    repeat (2) cyc(1'b0, 4'b0000);
    repeat (35) cyc(1'b1, 4'b0001);
    repeat (20) cyc(1'b1, 4'b0000);
    chk("mileage_35", mileage_bcd, 16'h0003);
    repeat (5) cyc(1'b1, 4'b0010);
    cyc(1'b1, 4'b0000);
    chk("mileage_hold", mileage_bcd, 16'h0004);

    // BCD digit carry 9 -> 10
    n = 0;
    while (units() != 10 && n < 200) begin cyc(1'b1, 4'b0011); n++; end
    chk("bcd_carry", mileage_bcd, 16'h0010);

    // power-off with coincident tick while blinking
    repeat (2) cyc(1'b0, 4'b0000);
    n = 0;
    while (units() != 7 && n < 200) begin cyc(1'b1, 4'b1001); n++; end
    chk("pre_off_mileage", mileage_bcd, 16'h0007);
    repeat (9) cyc(1'b1, 4'b1001);
    cyc(1'b0, 4'b1001);
    chk("off_left", 16'(left_led), 16'd0);
    chk("off_moving", 16'(moving), 16'd0);
    cyc(1'b0, 4'b1001);
    chk("off_mileage", mileage_bcd, 16'h0000);

    // random command runs
    for (int r = 0; r < 40; r++) begin
      p = ($urandom_range(0, 9) != 0);
      c = 4'($urandom);
      n = $urandom_range(1, 25);
      repeat (n) cyc(p, c);
    end

    // asynchronous reset mid-operation
    repeat (2) cyc(1'b0, 4'b0000);
    n = 0;
    while (units() != 12 && n < 300) begin cyc(1'b1, 4'b1001); n++; end
    chk("pre_rst_mileage", mileage_bcd, 16'h0012);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_left", 16'(left_led), 16'd0);
    chk("arst_moving", 16'(moving), 16'd0);
    chk("arst_mileage", mileage_bcd, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 4'b1001);
    cyc(1'b1, 4'b1001);
    chk("post_rst_mileage", mileage_bcd, 16'h0000);

    // fast instance: one unit per moving cycle, carry and 9999 wrap
    f_power = 1'b1;
    f_cmd = 4'b0001;
    n = 0;
    while (f_mileage !== 16'h0009 && n < 50) begin @(posedge clk); #1; n++; end
    chk("fast_reach_9", f_mileage, 16'h0009);
    chk("fast_moving", 16'(f_moving), 16'd1);
    chk("fast_leds", {14'd0, f_left, f_right}, 16'd0);
    @(posedge clk); #1;
    chk("fast_carry", f_mileage, 16'h0010);
    n = 0;
    while (f_mileage !== 16'h9999 && n < 12000) begin
      @(posedge clk); #1; n++;
      chk("fast_digits", 16'((f_mileage[3:0] <= 4'd9) && (f_mileage[7:4] <= 4'd9) &&
                             (f_mileage[11:8] <= 4'd9) && (f_mileage[15:12] <= 4'd9)), 16'd1);
    end
    chk("fast_reach_9999", f_mileage, 16'h9999);
    @(posedge clk); #1;
    chk("fast_wrap", f_mileage, 16'h0000);
    f_power = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drive_indicator.md
DRIVE_INDICATOR -- requirements
Module: drive_indicator

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 50_000_000, clock cycles per turn-LED half period (0.5 s at 100 MHz).
REQ-002 SHALL have parameter TICK_CYCLES, default 100_000_000, moving clock cycles per mileage unit (1 s at 100 MHz).
REQ-003 SHALL have port clk, input, 1, 100 MHz system clock (P17), all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port power_on, input, 1, car powered flag from the manual driving controller (1 = powered).
REQ-006 SHALL have port move_cmd, input, 4, motion command {left, right, back, fwd} from the manual driving controller, bit 3 = left.
REQ-007 SHALL have port left_led, output, 1, blinking left turn indicator.
REQ-008 SHALL have port right_led, output, 1, blinking right turn indicator.
REQ-009 SHALL have port moving, output, 1, registered flag, 1 while fwd or back is requested.
REQ-010 SHALL have port mileage_bcd, output, 16, four-digit BCD mileage, bits [15:12] = thousands.

Function
REQ-011 SHALL register power_on and move_cmd once on entry; all outputs derive from the registered copies (1-cycle input latency).
REQ-012 SHALL set moving = registered power_on AND (fwd OR back); fwd and back both 1 counts as moving, one unit per tick.
REQ-013 SHALL run a blink prescaler 0..BLINK_HALF-1 only while registered left or right is 1 and powered; on reaching BLINK_HALF-1 it wraps to 0 and toggles blink_phase.
REQ-014 SHALL hold the blink prescaler at 0 and blink_phase at 1 (ON) while neither turn bit is set, so a new turn request lights its LED in the first cycle after registration.
REQ-015 SHALL drive left_led = registered left AND blink_phase AND powered; right_led likewise; both bits set SHALL blink both LEDs in phase.
REQ-016 SHALL switch between left and right without resetting the phase when at least one turn bit stays set across the change.
REQ-017 SHALL run a mileage prescaler 0..TICK_CYCLES-1 only while moving = 1; while moving = 0 it holds its value (partial units retained, not cleared).
REQ-018 SHALL, in the cycle the mileage prescaler wraps from TICK_CYCLES-1 to 0, increment mileage_bcd by 1 in BCD, carrying digit 9 -> 0 with +1 to the next digit.
REQ-019 SHALL wrap mileage_bcd from 9999 to 0000 on increment with no other flag.
REQ-020 SHALL keep every BCD digit in 0..9 at all times.
REQ-021 SHALL, while registered power_on = 0, synchronously clear both prescalers and mileage_bcd, set blink_phase to 1, and force left_led, right_led, moving to 0.
REQ-022 SHALL give power-off clearing priority over a coincident mileage tick or blink toggle.

Reset
REQ-023 SHALL, on rst_n = 0 at any time including mid-count, asynchronously clear input registers, both prescalers and mileage_bcd to 0, set blink_phase to 1, and drive left_led = 0, right_led = 0, moving = 0, mileage_bcd = 16'h0000.
REQ-024 SHALL resume normal operation on the first rising clk edge after rst_n returns to 1.

Verification (BLINK_HALF = 4, TICK_CYCLES = 10)
REQ-025 Reset mid-operation: mileage 0x0012, assert rst_n = 0 between edges -> all outputs 0 immediately, mileage 0x0000 after release.
REQ-026 Blink: power_on = 1, move_cmd = 4'b1000 -> left_led 1 for 4 cycles, 0 for 4, repeating; right_led 0; first 1 one cycle after input change.
REQ-027 Mileage: move_cmd = 4'b0001 for 35 cycles -> mileage_bcd 0x0003, prescaler holds 5; move_cmd = 0 for 20 cycles then 4'b0010 for 5 cycles -> 0x0004.
REQ-028 BCD carry/wrap: preload by driving to 0x0009 then one tick -> 0x0010; from 0x9999 one tick -> 0x0000.
REQ-029 Power-off: mileage 0x0007, left blinking, power_on -> 0 -> next-plus-one cycle mileage 0x0000, LEDs 0, moving 0, even if tick coincides.
REQ-030 Both turns: move_cmd = 4'b1100 -> left_led and right_led identical square wave, period 8 cycles.
